sel_mux_pipe: RTL and testbench

- Parametrised, registered N:1 select multiplexer with a valid/ready handshake on input and output.
- Generalises the fixed 3-input, 3-bit clocked mux to NUM_IN channels of WIDTH bits.
- Adds a one-entry skid buffer for full throughput under backpressure, plus detection and counting of out-of-range selects.
- Sits between datapath source registers and consumers that can stall, such as the register-file write path and memory-interface staging.

---
 rtl/mux_pkg.sv | 21 ++
 rtl/skid_reg.sv | 57 +++++
 rtl/sel_mux_pipe.sv | 63 ++++++
 tb/tb_sel_mux_pipe.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared sizing helpers for the registered select mux and its skid stage.
package mux_pkg;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic logic [63:0] err_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic int ch_lo(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/skid_reg.sv
// skid_reg: output register plus one-entry skid buffer; in_ready is registered.
module skid_reg #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_in_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_out_ready
);
    logic             r_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_free;
    logic             w_push;
    logic             w_skid_full_next;

    assign w_free           = ~r_out_valid | i_out_ready;
    assign w_push           = i_valid & r_ready;
    assign w_skid_full_next = w_free ? (r_skid_valid & w_push) : (r_skid_valid | w_push);

    // a waiting skid beat always drains first so acceptance order is kept
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ready      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else begin
            r_ready <= ~w_skid_full_next;
            if (w_free) begin
                if (r_skid_valid) begin
                    r_out_data   <= r_skid_data;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= w_push;
                    if (w_push) r_skid_data <= i_data;
                end else begin
                    r_out_valid <= w_push;
                    if (w_push) r_out_data <= i_data;
                end
            end else if (w_push) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= i_data;
            end
        end
    end

    assign o_in_ready = r_ready;
    assign o_data     = r_out_data;
    assign o_valid    = r_out_valid;
endmodule

// File: rtl/sel_mux_pipe.sv
// sel_mux_pipe: registered N:1 select mux with valid/ready handshake;
// out-of-range selects are consumed, flagged and counted.
module sel_mux_pipe
    import mux_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter int WIDTH  = 3,
    parameter int SEL_W  = sel_width(NUM_IN),
    parameter int ERR_W  = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    output logic [ERR_W-1:0]        err_count
);
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(err_max(ERR_W));

    logic [WIDTH-1:0] w_sel_data;
    logic             w_good;
    logic             w_bad_acc;
    logic             r_sel_err;
    logic [ERR_W-1:0] r_err_count;

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NUM_IN; k++)
            if (sel == SEL_W'(k)) w_sel_data = in_data[ch_lo(k, WIDTH) +: WIDTH];
    end

    assign w_good    = int'(sel) < NUM_IN;
    assign w_bad_acc = in_valid & in_ready & ~w_good;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sel_err   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_sel_err <= w_bad_acc;
            if (w_bad_acc && r_err_count != ERR_MAX) r_err_count <= r_err_count + 1'b1;
        end
    end

    skid_reg #(.WIDTH(WIDTH)) u_skid (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_data      (w_sel_data),
        .i_valid     (in_valid & w_good),
        .o_in_ready  (in_ready),
        .o_data      (out_data),
        .o_valid     (out_valid),
        .i_out_ready (out_ready)
    );

    assign sel_err   = r_sel_err;
    assign err_count = r_err_count;
endmodule

// File: tb/tb_sel_mux_pipe.sv
// tb_sel_mux_pipe: directed checks of a 4-input and a 3-input build sharing clock and reset.
module tb_sel_mux_pipe;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] in_data4 = 32'h44332211;
    logic [1:0]  sel4 = '0;
    logic        in_valid4 = 1'b0, out_ready4 = 1'b0;
    logic        in_ready4, out_valid4, sel_err4;
    logic [7:0]  out_data4;
    logic [3:0]  err_count4;
    logic [23:0] in_data3 = 24'h332211;
    logic [1:0]  sel3 = '0;
    logic        in_valid3 = 1'b0, out_ready3 = 1'b0;
    logic        in_ready3, out_valid3, sel_err3;
    logic [7:0]  out_data3;
    logic [3:0]  err_count3;
    int          total = 0;
    int          passed = 0;

    always #5 clock = ~clock;

    sel_mux_pipe #(.NUM_IN(4), .WIDTH(8), .ERR_W(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .in_data(in_data4), .sel(sel4),
        .in_valid(in_valid4), .in_ready(in_ready4), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .sel_err(sel_err4),
        .err_count(err_count4)
    );

    sel_mux_pipe #(.NUM_IN(3), .WIDTH(8), .ERR_W(4)) dut3 (
        .clock(clock), .reset_n(reset_n), .in_data(in_data3), .sel(sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .sel_err(sel_err3),
        .err_count(err_count3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_out_valid", out_valid4, 0);
        chk("rst_out_data", out_data4, 0);
        chk("rst_in_ready", in_ready4, 0);
        chk("rst_err_count", err_count4, 0);
        chk("rst_sel_err", sel_err4, 0);
        reset_n = 1'b1;
        #1 chk("ready_before_edge", in_ready4, 0);
        tick();
        chk("ready_after_edge", in_ready4, 1);
        chk("ready_after_edge3", in_ready3, 1);

        out_ready4 = 1'b1; in_valid4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel4 = 2'(i);
            tick();
            chk("stream_valid", out_valid4, 1);
            chk("stream_data", out_data4, 32'h11 * (i + 1));
            chk("stream_ready", in_ready4, 1);
        end
        in_valid4 = 1'b0;
        tick();
        chk("stream_idle", out_valid4, 0);

        out_ready4 = 1'b0; in_valid4 = 1'b1; sel4 = 2'd2;
        tick();
        chk("bp_first_data", out_data4, 32'h33);
        chk("bp_first_ready", in_ready4, 1);
        sel4 = 2'd1;
        tick();
        chk("bp_hold_data", out_data4, 32'h33);
        chk("bp_ready_low", in_ready4, 0);
        sel4 = 2'd3;
        repeat (2) begin
            tick();
            chk("bp_stall_data", out_data4, 32'h33);
            chk("bp_stall_valid", out_valid4, 1);
            chk("bp_stall_ready", in_ready4, 0);
        end
        out_ready4 = 1'b1;
        tick();
        chk("bp_rel_skid", out_data4, 32'h22);
        chk("bp_rel_valid", out_valid4, 1);
        chk("bp_rel_ready", in_ready4, 1);
        tick();
        chk("bp_rel_third", out_data4, 32'h44);
        in_valid4 = 1'b0;
        tick();
        chk("bp_drained", out_valid4, 0);

        out_ready3 = 1'b1; in_valid3 = 1'b1; sel3 = 2'd3;
        tick();
        chk("bad_no_valid", out_valid3, 0);
        chk("bad_sel_err", sel_err3, 1);
        chk("bad_count", err_count3, 1);
        chk("bad_ready", in_ready3, 1);
        in_valid3 = 1'b0;
        tick();
        chk("bad_pulse_end", sel_err3, 0);
        chk("bad_count_hold", err_count3, 1);
        in_valid3 = 1'b1; sel3 = 2'd1;
        tick();
        chk("good3_data", out_data3, 32'h22);
        sel3 = 2'd3;
        tick();
        chk("bad_drain_valid", out_valid3, 0);
        chk("bad_drain_count", err_count3, 2);
        chk("bad_drain_data", out_data3, 32'h22);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("sat_sel_err", sel_err3, 1);
        end
        chk("sat_count", err_count3, 15);
        in_valid3 = 1'b0;
        tick();
        chk("sat_hold", err_count3, 15);
        chk("sat_pulse_end", sel_err3, 0);

        out_ready4 = 1'b0; in_valid4 = 1'b1; sel4 = 2'd2;
        tick();
        sel4 = 2'd1;
        tick();
        in_valid4 = 1'b0;
        chk("mid_pre_valid", out_valid4, 1);
        chk("mid_pre_ready", in_ready4, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_async_valid", out_valid4, 0);
        chk("mid_async_data", out_data4, 0);
        chk("mid_async_ready", in_ready4, 0);
        chk("mid_async_err3", err_count3, 0);
        reset_n = 1'b1;
        out_ready4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_stale", out_valid4, 0);
        end
        chk("mid_ready", in_ready4, 1);
        in_valid4 = 1'b1; sel4 = 2'd0;
        tick();
        chk("mid_fresh_data", out_data4, 32'h11);
        chk("mid_fresh_valid", out_valid4, 1);
        in_valid4 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
